// File: rtl/eth_rx_pkt_buffer.sv
// ============================================================================
// Module   : eth_rx_pkt_buffer
// Purpose  : Store-and-forward RX packet buffer for a 256-bit Avalon-ST MAC.
//            Optional macro ETH_RX_BUF_STATS_EN enables the packet counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eth_rx_pkt_buffer #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] rx_data_in,
  input  logic         rx_valid_in,
  input  logic         rx_sop_in,
  input  logic         rx_eop_in,
  input  logic [4:0]   rx_empty_in,
  input  logic [5:0]   rx_error_in,
  output logic         rx_ready_out,
  output logic [255:0] out_data,
  output logic [4:0]   out_empty,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop,
  input  logic         out_ready,
  output logic [31:0]  stat_pkt_ok,
  output logic [31:0]  stat_pkt_drop
);

  localparam int c_depth   = 1 << DEPTH_LOG2;
  localparam int c_entry_w = 256 + 1 + 1 + 5;
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_wr_commit;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [c_entry_w-1:0]    r_mem [c_depth];
  logic [c_entry_w-1:0]    r_rd_q;
  logic                    r_q_valid;

  state_t                  w_state_nxt;
  logic [DEPTH_LOG2-1:0]   w_ptr_nxt;
  logic [DEPTH_LOG2-1:0]   w_commit_nxt;
  logic [DEPTH_LOG2-1:0]   w_waddr;
  logic                    w_we;
  logic                    w_ok;
  logic [1:0]              w_drop_n;
  logic                    w_full_cur;
  logic                    w_full_base;
  logic                    w_err;
  logic                    w_out_load;
  logic                    w_rd_en;

  assign rx_ready_out = !reset;
  assign w_err        = |rx_error_in;
  assign w_full_cur   = (r_wr_ptr + c_ptr_one) == r_rd_ptr;
  // A restarted packet writes from the commit point, so fullness is judged there
  assign w_full_base  = (r_wr_commit + c_ptr_one) == r_rd_ptr;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_wr_ptr;
    w_commit_nxt = r_wr_commit;
    w_waddr      = r_wr_ptr;
    w_we         = 1'b0;
    w_ok         = 1'b0;
    w_drop_n     = 2'd0;
    if (rx_valid_in) begin
      if (rx_sop_in) begin
        if (r_state != ST_IDLE) begin
          w_drop_n  = 2'd1;
          w_ptr_nxt = r_wr_commit;
        end
        if (w_full_base) begin
          if (rx_eop_in) begin
            w_drop_n    = w_drop_n + 2'd1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end else begin
          w_we      = 1'b1;
          w_waddr   = r_wr_commit;
          w_ptr_nxt = r_wr_commit + c_ptr_one;
          if (rx_eop_in && !w_err) begin
            w_commit_nxt = r_wr_commit + c_ptr_one;
            w_ok         = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else if (rx_eop_in) begin
            w_ptr_nxt   = r_wr_commit;
            w_drop_n    = w_drop_n + 2'd1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RECV;
          end
        end
      end else begin
        case (r_state)
          ST_RECV: begin
            if (w_full_cur) begin
              if (rx_eop_in) begin
                w_ptr_nxt   = r_wr_commit;
                w_drop_n    = 2'd1;
                w_state_nxt = ST_IDLE;
              end else begin
                w_state_nxt = ST_DROP;
              end
            end else begin
              w_we      = 1'b1;
              w_ptr_nxt = r_wr_ptr + c_ptr_one;
              if (rx_eop_in && !w_err) begin
                w_commit_nxt = r_wr_ptr + c_ptr_one;
                w_ok         = 1'b1;
                w_state_nxt  = ST_IDLE;
              end else if (rx_eop_in) begin
                w_ptr_nxt   = r_wr_commit;
                w_drop_n    = 2'd1;
                w_state_nxt = ST_IDLE;
              end
            end
          end
          ST_DROP: begin
            if (rx_eop_in) begin
              w_ptr_nxt   = r_wr_commit;
              w_drop_n    = 2'd1;
              w_state_nxt = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_ptr_nxt;
      r_wr_commit <= w_commit_nxt;
    end
  end

  // Two-stage read: RAM output register, then the downstream output register
  assign w_out_load = r_q_valid && (!out_valid || out_ready);
  assign w_rd_en    = (r_rd_ptr != r_wr_commit) && (!r_q_valid || w_out_load);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= {rx_data_in, rx_sop_in, rx_eop_in, rx_empty_in};
    end
    if (w_rd_en) begin
      r_rd_q <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_q_valid <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + c_ptr_one;
        r_q_valid <= 1'b1;
      end else if (w_out_load) begin
        r_q_valid <= 1'b0;
      end
      if (w_out_load) begin
        out_valid <= 1'b1;
        out_data  <= r_rd_q[c_entry_w-1:7];
        out_sop   <= r_rd_q[6];
        out_eop   <= r_rd_q[5];
        out_empty <= r_rd_q[4:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ETH_RX_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkt_ok   <= '0;
      stat_pkt_drop <= '0;
    end else begin
      stat_pkt_ok   <= stat_pkt_ok + {31'd0, w_ok};
      stat_pkt_drop <= stat_pkt_drop + {30'd0, w_drop_n};
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{w_ok, w_drop_n};
  assign stat_pkt_ok    = '0;
  assign stat_pkt_drop  = '0;
`endif

endmodule

`default_nettype wire
